// File: rtl/vga_sram_arbiter.sv
// Async SRAM arbiter, VGA read port vs frame-fill write port; `VGA_SRAM_ARB_STATS_EN adds rd_count/wr_count.
// Read 3 cycles accept-to-response, write 4 cycles; readies only in IDLE, writes bounded by MAX_RD_STREAK.
module vga_sram_arbiter #(
    parameter int ADDR_BITS     = 20,
    parameter int DATA_BITS     = 16,
    parameter int MAX_RD_STREAK = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rd_req_valid,
    input  logic [ADDR_BITS-1:0] rd_req_addr,
    output logic                 rd_req_ready,
    output logic                 rd_resp_valid,
    output logic [DATA_BITS-1:0] rd_resp_data,
    input  logic                 wr_req_valid,
    input  logic [ADDR_BITS-1:0] wr_req_addr,
    input  logic [DATA_BITS-1:0] wr_req_data,
    output logic                 wr_req_ready,
    output logic [ADDR_BITS-1:0] sram_addr,
    output logic [DATA_BITS-1:0] sram_data_o,
    output logic                 sram_data_oe,
    input  logic [DATA_BITS-1:0] sram_data_i,
    output logic                 sram_ce_n,
    output logic                 sram_oe_n,
    output logic                 sram_we_n
`ifdef VGA_SRAM_ARB_STATS_EN
    ,
    output logic [31:0]          rd_count,
    output logic [31:0]          wr_count
`endif
);

    localparam int SW = (MAX_RD_STREAK > 0) ? $clog2(MAX_RD_STREAK + 1) : 1;
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_RD_STREAK);

    typedef enum logic [2:0] {
        IDLE,
        RD0,
        RD1,
        WR_SETUP,
        WR_PULSE,
        WR_HOLD
    } state_t;

    state_t               state_q, state_d;
    logic [ADDR_BITS-1:0] addr_q, addr_d;
    logic [DATA_BITS-1:0] wdata_q, wdata_d;
    logic                 resp_vld_q, resp_vld_d;
    logic [DATA_BITS-1:0] resp_dat_q, resp_dat_d;
    logic [SW-1:0]        streak_q, streak_d;
    logic                 grant_rd;
    logic                 rd_acc;
    logic                 wr_acc;

    always_comb begin
        grant_rd = rd_req_valid && !(wr_req_valid && (streak_q == STREAK_MAX));
        rd_acc   = (state_q == IDLE) && grant_rd;
        wr_acc   = (state_q == IDLE) && wr_req_valid && !grant_rd;
    end

    assign rd_req_ready = rd_acc;
    assign wr_req_ready = wr_acc;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        resp_vld_d = 1'b0;
        resp_dat_d = resp_dat_q;
        streak_d   = streak_q;

        // Streak only counts reads that jumped ahead of a waiting write.
        if (!wr_req_valid || wr_acc) begin
            streak_d = '0;
        end else if (rd_acc && (streak_q != STREAK_MAX)) begin
            streak_d = streak_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (rd_acc) begin
                    state_d = RD0;
                    addr_d  = rd_req_addr;
                end else if (wr_acc) begin
                    state_d = WR_SETUP;
                    addr_d  = wr_req_addr;
                    wdata_d = wr_req_data;
                end
            end
            RD0:      state_d = RD1;
            RD1: begin
                state_d    = IDLE;
                resp_vld_d = 1'b1;
                resp_dat_d = sram_data_i;
            end
            WR_SETUP: state_d = WR_PULSE;
            WR_PULSE: state_d = WR_HOLD;
            WR_HOLD:  state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Strobes decode straight from state so an async reset deasserts them immediately.
    always_comb begin
        sram_ce_n    = 1'b1;
        sram_oe_n    = 1'b1;
        sram_we_n    = 1'b1;
        sram_data_oe = 1'b0;
        case (state_q)
            RD0, RD1: begin
                sram_ce_n = 1'b0;
                sram_oe_n = 1'b0;
            end
            WR_SETUP, WR_HOLD: begin
                sram_ce_n    = 1'b0;
                sram_data_oe = 1'b1;
            end
            WR_PULSE: begin
                sram_ce_n    = 1'b0;
                sram_we_n    = 1'b0;
                sram_data_oe = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            resp_vld_q <= 1'b0;
            resp_dat_q <= '0;
            streak_q   <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            resp_vld_q <= resp_vld_d;
            resp_dat_q <= resp_dat_d;
            streak_q   <= streak_d;
        end
    end

    assign sram_addr     = addr_q;
    assign sram_data_o   = wdata_q;
    assign rd_resp_valid = resp_vld_q;
    assign rd_resp_data  = resp_dat_q;

`ifdef VGA_SRAM_ARB_STATS_EN
    logic [31:0] rd_count_q, rd_count_d;
    logic [31:0] wr_count_q, wr_count_d;

    always_comb begin
        rd_count_d = rd_count_q + {31'd0, rd_acc};
        wr_count_d = wr_count_q + {31'd0, wr_acc};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_count_q <= '0;
            wr_count_q <= '0;
        end else begin
            rd_count_q <= rd_count_d;
            wr_count_q <= wr_count_d;
        end
    end

    assign rd_count = rd_count_q;
    assign wr_count = wr_count_q;
`endif

endmodule

// File: tb/tb_vga_sram_arbiter.sv
// Directed bench for vga_sram_arbiter: instance a (MAX_RD_STREAK=4) on an SRAM model, instance b (MAX_RD_STREAK=0).
module tb_vga_sram_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rd_req_valid = 1'b0;
    logic [19:0] rd_req_addr = '0;
    logic        wr_req_valid = 1'b0;
    logic [19:0] wr_req_addr = '0;
    logic [15:0] wr_req_data = '0;
    logic [15:0] sram_data_i = '0;
    logic [15:0] zero_data = '0;

    logic        rd_rdy_a, rd_vld_a, wr_rdy_a, doe_a, ce_n_a, oe_n_a, we_n_a;
    logic [15:0] rd_dat_a, dout_a;
    logic [19:0] addr_a;
    logic        rd_rdy_b, rd_vld_b, wr_rdy_b, doe_b, ce_n_b, oe_n_b, we_n_b;
    logic [15:0] rd_dat_b, dout_b;
    logic [19:0] addr_b;
`ifdef VGA_SRAM_ARB_STATS_EN
    logic [31:0] rd_cnt_a, wr_cnt_a, rd_cnt_b, wr_cnt_b;
`endif

    int n_checks = 0;
    int n_pass = 0;
    int conflicts = 0;
    int both_rdy = 0;
    logic [15:0] mem [logic [19:0]];

    always #5 clk = ~clk;

    vga_sram_arbiter #(.ADDR_BITS(20), .DATA_BITS(16), .MAX_RD_STREAK(4)) dut_a (
        .clk(clk), .reset(reset),
        .rd_req_valid(rd_req_valid), .rd_req_addr(rd_req_addr), .rd_req_ready(rd_rdy_a),
        .rd_resp_valid(rd_vld_a), .rd_resp_data(rd_dat_a),
        .wr_req_valid(wr_req_valid), .wr_req_addr(wr_req_addr), .wr_req_data(wr_req_data),
        .wr_req_ready(wr_rdy_a),
        .sram_addr(addr_a), .sram_data_o(dout_a), .sram_data_oe(doe_a), .sram_data_i(sram_data_i),
        .sram_ce_n(ce_n_a), .sram_oe_n(oe_n_a), .sram_we_n(we_n_a)
`ifdef VGA_SRAM_ARB_STATS_EN
        , .rd_count(rd_cnt_a), .wr_count(wr_cnt_a)
`endif
    );

    vga_sram_arbiter #(.ADDR_BITS(20), .DATA_BITS(16), .MAX_RD_STREAK(0)) dut_b (
        .clk(clk), .reset(reset),
        .rd_req_valid(rd_req_valid), .rd_req_addr(rd_req_addr), .rd_req_ready(rd_rdy_b),
        .rd_resp_valid(rd_vld_b), .rd_resp_data(rd_dat_b),
        .wr_req_valid(wr_req_valid), .wr_req_addr(wr_req_addr), .wr_req_data(wr_req_data),
        .wr_req_ready(wr_rdy_b),
        .sram_addr(addr_b), .sram_data_o(dout_b), .sram_data_oe(doe_b), .sram_data_i(zero_data),
        .sram_ce_n(ce_n_b), .sram_oe_n(oe_n_b), .sram_we_n(we_n_b)
`ifdef VGA_SRAM_ARB_STATS_EN
        , .rd_count(rd_cnt_b), .wr_count(wr_cnt_b)
`endif
    );

    // Asynchronous SRAM model for instance a, evaluated mid-cycle.
    initial begin
        mem[20'h00123] = 16'hBEEF;
        mem[20'h00777] = 16'hA5A5;
        forever begin
            @(negedge clk);
            if (!oe_n_a && doe_a) conflicts++;
            if (!ce_n_a && !we_n_a) mem[addr_a] = dout_a;
            if (!ce_n_a && !oe_n_a) sram_data_i = mem.exists(addr_a) ? mem[addr_a] : 16'h0000;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [19:0] a, input logic [15:0] d);
        int k;
        wr_req_addr  = a;
        wr_req_data  = d;
        wr_req_valid = 1'b1;
        k = 0;
        @(negedge clk);
        while (!wr_rdy_a && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("wr_accept", {31'd0, wr_rdy_a}, 32'd1);
        step();
        wr_req_valid = 1'b0;
    endtask

    task automatic do_read(input logic [19:0] a, output logic [15:0] d);
        int k;
        rd_req_addr  = a;
        rd_req_valid = 1'b1;
        k = 0;
        @(negedge clk);
        while (!rd_rdy_a && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("rd_accept", {31'd0, rd_rdy_a}, 32'd1);
        step();
        rd_req_valid = 1'b0;
        k = 0;
        @(negedge clk);
        while (!rd_vld_a && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("rd_resp_vld", {31'd0, rd_vld_a}, 32'd1);
        d = rd_dat_a;
        step();
    endtask

    initial begin
        logic [15:0] rdata;
        string exp_a = "RRRRWRRRRW";
        string exp_b = "WWWW";
        logic [7:0] ga [10];
        logic [7:0] gb [4];
        int na, nb, cyc;

        // Reset state
        #3;
        check("rst_ce_n", {31'd0, ce_n_a}, 32'd1);
        check("rst_oe_n", {31'd0, oe_n_a}, 32'd1);
        check("rst_we_n", {31'd0, we_n_a}, 32'd1);
        check("rst_data_oe", {31'd0, doe_a}, 32'd0);
        check("rst_addr", {12'd0, addr_a}, 32'd0);
        check("rst_data_o", {16'd0, dout_a}, 32'd0);
        check("rst_resp", {15'd0, rd_vld_a, rd_dat_a}, 32'd0);
        repeat (2) step();
        reset = 1'b0;
        step();

        // Single read of 0x00123
        rd_req_addr  = 20'h00123;
        rd_req_valid = 1'b1;
        @(negedge clk);
        check("rd_c0_ready", {30'd0, rd_rdy_a, wr_rdy_a}, 32'd2);
        step();
        rd_req_valid = 1'b0;
        @(negedge clk);
        check("rd_c1_strobes", {29'd0, ce_n_a, oe_n_a, doe_a}, 32'd0);
        check("rd_c1_addr", {12'd0, addr_a}, 32'h00123);
        check("rd_c1_rdy_vld", {30'd0, rd_rdy_a, rd_vld_a}, 32'd0);
        step();
        @(negedge clk);
        check("rd_c2_strobes", {28'd0, ce_n_a, oe_n_a, we_n_a, doe_a}, 32'd2);
        check("rd_c2_vld", {31'd0, rd_vld_a}, 32'd0);
        step();
        @(negedge clk);
        check("rd_c3_strobes", {30'd0, ce_n_a, oe_n_a}, 32'd3);
        check("rd_c3_resp", {15'd0, rd_vld_a, rd_dat_a}, 32'h1BEEF);
        step();
        @(negedge clk);
        check("rd_c4_resp", {15'd0, rd_vld_a, rd_dat_a}, 32'h0BEEF);
        step();

        // Write 0xF000 to 0x4AFFF, request held to observe the 4-cycle turnaround
        wr_req_addr  = 20'h4AFFF;
        wr_req_data  = 16'hF000;
        wr_req_valid = 1'b1;
        @(negedge clk);
        check("wr_c0_ready", {30'd0, rd_rdy_a, wr_rdy_a}, 32'd1);
        step();
        @(negedge clk);
        check("wr_c1_strobes", {27'd0, wr_rdy_a, ce_n_a, oe_n_a, we_n_a, doe_a}, 32'h7);
        check("wr_c1_bus", {addr_a[15:0], dout_a}, 32'hAFFF_F000);
        step();
        @(negedge clk);
        check("wr_c2_strobes", {27'd0, wr_rdy_a, ce_n_a, oe_n_a, we_n_a, doe_a}, 32'h5);
        step();
        @(negedge clk);
        check("wr_c3_strobes", {27'd0, wr_rdy_a, ce_n_a, oe_n_a, we_n_a, doe_a}, 32'h7);
        step();
        @(negedge clk);
        check("wr_c4_idle", {27'd0, wr_rdy_a, ce_n_a, oe_n_a, we_n_a, doe_a}, 32'h1E);
        step();
        wr_req_valid = 1'b0;
        repeat (4) step();
        check("wr_mem", {16'd0, mem.exists(20'h4AFFF) ? mem[20'h4AFFF] : 16'h0000}, 32'h0000F000);

        // Both requesters held: a grants R,R,R,R,W; b gives every conflict to the write
        rd_req_addr  = 20'h00010;
        wr_req_addr  = 20'h00020;
        wr_req_data  = 16'h1234;
        rd_req_valid = 1'b1;
        wr_req_valid = 1'b1;
        na = 0;
        nb = 0;
        cyc = 0;
        while ((na < 10 || nb < 4) && cyc < 200) begin
            @(negedge clk);
            if (rd_rdy_a && wr_rdy_a) both_rdy++;
            if (rd_rdy_b && wr_rdy_b) both_rdy++;
            if (na < 10 && (rd_rdy_a || wr_rdy_a)) begin
                ga[na] = rd_rdy_a ? 8'h52 : 8'h57;
                na++;
            end
            if (nb < 4 && (rd_rdy_b || wr_rdy_b)) begin
                gb[nb] = rd_rdy_b ? 8'h52 : 8'h57;
                nb++;
            end
            cyc++;
        end
        step();
        rd_req_valid = 1'b0;
        wr_req_valid = 1'b0;
        check("stream_grants", na + nb, 14);
        for (int i = 0; i < na; i++) check($sformatf("grant_a_%0d", i), {24'd0, ga[i]}, {24'd0, exp_a[i]});
        for (int i = 0; i < nb; i++) check($sformatf("grant_b_%0d", i), {24'd0, gb[i]}, {24'd0, exp_b[i]});
        check("both_ready", both_rdy, 0);
        repeat (6) step();

        // Reset in the middle of WR_PULSE
        wr_req_addr  = 20'h00055;
        wr_req_data  = 16'hAAAA;
        wr_req_valid = 1'b1;
        cyc = 0;
        @(negedge clk);
        while (we_n_a && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("wr_pulse_seen", {31'd0, we_n_a}, 32'd0);
        reset = 1'b1;
        #1;
        check("rst_mid_strobes", {28'd0, ce_n_a, oe_n_a, we_n_a, doe_a}, 32'hE);
        check("rst_mid_idle", {31'd0, wr_rdy_a}, 32'd1);
        wr_req_valid = 1'b0;
        step();
        step();
        reset = 1'b0;
        step();
        do_read(20'h00777, rdata);
        check("post_rst_read", {16'd0, rdata}, 32'h0000A5A5);

        // Reduced frame fill and read-back
        for (int i = 0; i < 64; i++) do_write(20'h01000 + 20'(i), 16'(i * 37 + 16'h1357));
        repeat (4) step();
        for (int i = 0; i < 64; i++) begin
            do_read(20'h01000 + 20'(i), rdata);
            check($sformatf("fill_%0d", i), {16'd0, rdata}, {16'd0, 16'(i * 37 + 16'h1357)});
        end
`ifdef VGA_SRAM_ARB_STATS_EN
        check("rd_count", rd_cnt_a, 32'd65);
        check("wr_count", wr_cnt_a, 32'd64);
`endif
        check("bus_conflict", conflicts, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
